// File: rtl/gpr_file_sb_pkg.sv
// Shared constants, output-stage state encoding and address helpers for the
// integer register file with pending-write scoreboard.
package gpr_file_sb_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // True when an enabled port targets the given non-zero register.
    function automatic logic addr_hit(input logic          en,
                                      input logic [AW-1:0] port_addr,
                                      input logic [AW-1:0] reg_addr);
        return en && (port_addr == reg_addr) && (reg_addr != '0);
    endfunction

    // Address is the hardwired zero register.
    function automatic logic is_x0(input logic [AW-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Per-register pending bits. A reserve marks a register as awaiting a result,
// a write-back clears it; when both hit the same register in one cycle the
// reserve wins because it belongs to the newer producer. Each source lookup
// reports whether the operand can be read this cycle, counting an in-flight
// write-back as resolving the hazard.
module gpr_file_sb_scoreboard
    import gpr_file_sb_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          rsv_en_i,
    input  logic [AW-1:0] rsv_addr_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          ok1_o,
    output logic          ok2_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Next pend vector: clear on write-back, then set on reserve; x0 never pends.
    always_comb begin
        pend_d = pend_q;
        if (wb_en_i) begin
            pend_d[wb_addr_i] = 1'b0;
        end
        if (rsv_en_i) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pend register; the same-cycle reserve is invisible to lookups until next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Source lookups against the registered pend state plus the live write-back.
    always_comb begin
        ok1_o = is_x0(rs1_i) || !pend_q[rs1_i] || addr_hit(wb_en_i, wb_addr_i, rs1_i);
        ok2_o = is_x0(rs2_i) || !pend_q[rs2_i] || addr_hit(wb_en_i, wb_addr_i, rs2_i);
    end

endmodule

// File: rtl/gpr_file_sb.sv
// 32-entry integer register file between issue and execute. One write-back
// port, one operand-read port with valid/ready handshake and a one-deep
// registered output stage. Reads stall while a needed source is pending and
// not being written back this cycle; a same-cycle write-back is bypassed.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  OUT_EMPTY | no operand pair held; a read may fire whenever sources are ok
//  OUT_FULL  | operand pair held on rs*_data_o; stable until out_ready_i
module gpr_file_sb
    import gpr_file_sb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            rsv_en_i,
    input  logic [AW-1:0]   rsv_addr_i,
    input  logic            rd_valid_i,
    output logic            rd_ready_o,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            ok1;
    logic            ok2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            fire;
    out_state_e      state_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;

    gpr_file_sb_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .ok1_o      (ok1),
        .ok2_o      (ok2)
    );

    // Register array; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_i && !is_x0(wb_addr_i)) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Operand muxes: x0 reads zero, a live write-back bypasses the array.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (!is_x0(rs1_i)) begin
            rs1_val = addr_hit(wb_en_i, wb_addr_i, rs1_i) ? wb_data_i : regs_q[rs1_i];
        end
        if (!is_x0(rs2_i)) begin
            rs2_val = addr_hit(wb_en_i, wb_addr_i, rs2_i) ? wb_data_i : regs_q[rs2_i];
        end
    end

    // Ready never looks at rd_valid_i, so issue can use it to decide whether to present.
    always_comb begin
        rd_ready_o = ok1 && ok2 && ((state_q == OUT_EMPTY) || out_ready_i);
        fire       = rd_valid_i && rd_ready_o;
    end

    // Output stage: captures the operand pair on fire and holds it until consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= OUT_EMPTY;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (fire) begin
                        state_q    <= OUT_FULL;
                        rs1_data_q <= rs1_val;
                        rs2_data_q <= rs2_val;
                    end
                end
                OUT_FULL: begin
                    if (fire) begin
                        rs1_data_q <= rs1_val;
                        rs2_data_q <= rs2_val;
                    end else if (out_ready_i) begin
                        state_q <= OUT_EMPTY;
                    end
                end
                default: begin
                    state_q <= OUT_EMPTY;
                end
            endcase
        end
    end

    assign out_valid_o = (state_q == OUT_FULL);
    assign rs1_data_o  = rs1_data_q;
    assign rs2_data_o  = rs2_data_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_en_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        rsv_en_i = 1'b0;
    logic [4:0]  rsv_addr_i = '0;
    logic        rd_valid_i = 1'b0;
    logic        rd_ready_o;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;

    gpr_file_sb dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb_en_i     (wb_en_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .rsv_en_i    (rsv_en_i),
        .rsv_addr_i  (rsv_addr_i),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t       exp_q[$];
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_full;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference view of a source: readable unless pending and not being written now.
    function automatic bit m_ok(input logic [4:0] rs);
        return (rs == 0) || !m_pend[rs] || (wb_en_i && wb_addr_i == rs);
    endfunction

    function automatic logic [31:0] m_val(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (wb_en_i && wb_addr_i == rs) return wb_data_i;
        return m_regs[rs];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_full = 0;
        exp_q.delete();
    endtask

    // One clock: check ready, enqueue expected pair on fire, then advance the model.
    task automatic step();
        bit exp_rdy;
        bit fire;
        @(negedge clk_i);
        #2;
        exp_rdy = m_ok(rs1_i) && m_ok(rs2_i) && (!m_full || out_ready_i);
        n_cmp++;
        if (rd_ready_o !== exp_rdy) begin
            n_bad++;
            $display("FAIL rd_ready rs1=%0d rs2=%0d: got %b want %b", rs1_i, rs2_i, rd_ready_o, exp_rdy);
        end
        fire = rd_valid_i && exp_rdy;
        if (fire) exp_q.push_back('{a: m_val(rs1_i), b: m_val(rs2_i)});
        m_full = fire || (m_full && !out_ready_i);
        @(posedge clk_i);
        if (wb_en_i && wb_addr_i != 0) begin
            m_regs[wb_addr_i] = wb_data_i;
            m_pend[wb_addr_i] = 0;
        end
        if (rsv_en_i && rsv_addr_i != 0) m_pend[rsv_addr_i] = 1;
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic rv, input logic [4:0] s1, input logic [4:0] s2,
                         input logic ordy);
        wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
        rsv_en_i = re; rsv_addr_i = ra;
        rd_valid_i = rv; rs1_i = s1; rs2_i = s2;
        out_ready_i = ordy;
        step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Asynchronous reset in mid-cycle: the held pair must vanish at once.
    task automatic do_reset();
        wb_en_i = 0; rsv_en_i = 0; rd_valid_i = 0; out_ready_i = 1;
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b d1=%h d2=%h want 0/0/0", out_valid_o, rs1_data_o, rs2_data_o);
        end
        m_clear();
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: whenever the DUT presents a pair it must match the oldest expected one.
    always begin
        @(negedge clk_i);
        #1;
        if (rst_ni) begin
            if (out_valid_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected: got d1=%h d2=%h want no output", rs1_data_o, rs2_data_o);
                end else begin
                    if (rs1_data_o !== exp_q[0].a || rs2_data_o !== exp_q[0].b) begin
                        n_bad++;
                        $display("FAIL out_data: got d1=%h d2=%h want d1=%h d2=%h",
                                 rs1_data_o, rs2_data_o, exp_q[0].a, exp_q[0].b);
                    end
                    if (out_ready_i) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_missing: got valid=0 want valid=1 d1=%h", exp_q[0].a);
            end
        end
    end

    initial begin
        m_clear();
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b d1=%h d2=%h want 0/0/0", out_valid_o, rs1_data_o, rs2_data_o);
        end
        rst_ni = 1'b1;

        // Read after reset.
        drive(0, 0, 0, 0, 0, 1, 3, 0, 1);
        idle();
        // Write-back then read, and same-cycle bypass.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 5, 0, 1);
        drive(1, 5, 32'hCAFEF00D, 0, 0, 1, 5, 5, 1);
        idle();
        // Reserve stalls until the write-back arrives, which resolves in its own cycle.
        drive(0, 0, 0, 1, 7, 0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 1, 7, 0, 1);
        drive(1, 7, 32'h1234, 0, 0, 1, 7, 0, 1);
        idle();
        // x0 ignores writes and reserves.
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        idle();
        // Held pair must not change under a later write; then back-to-back accepts.
        drive(0, 0, 0, 0, 0, 1, 5, 5, 0);
        drive(1, 5, 32'h1, 0, 0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5, 7, 1);
        drive(0, 0, 0, 0, 0, 1, 7, 5, 1);
        idle();
        // Reserve read in the same cycle sees pre-reserve state.
        drive(0, 0, 0, 1, 6, 1, 6, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 6, 0, 1);
        drive(1, 6, 32'h66, 0, 0, 0, 0, 0, 1);
        // Same-cycle write-back and reserve leave x9 pending; reset clears it.
        drive(1, 9, 32'h99, 1, 9, 0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 1, 9, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 9, 0, 1);
        idle();

        // Randomized traffic on a narrow address window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            drive($urandom_range(0, 9) < 4,
                  ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                  $urandom(),
                  $urandom_range(0, 9) < 3,
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 7,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 7);
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
